hc595_capture: RTL and testbench

Receive-side counterpart of the 74HC595 display driver: oversamples the serial shcp/stcp/ds/oe lines on sys_clk and rebuilds the segment/select word exactly as two cascaded 74HC595s would. It decodes each latched frame back into a 6-digit display buffer. It sits in the bench and in on-chip self-check builds, so RAM read data shown on the display can be compared numerically rather than by eye.

---
 rtl/hc595_pkg.sv | 50 +++++
 rtl/hc595_capture_seg7_decode.sv | 41 ++++
 rtl/hc595_capture.sv | 119 +++++++++++
 tb/tb_hc595_capture.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hc595_pkg.sv
// Shared constants for the 74HC595 display path: frame layout, segment patterns
// (active-low, seg[7] = dp) and small helpers used by the capture block.
package hc595_pkg;

  localparam int FRAME_BITS_DEF = 14;
  localparam int NUM_DIGITS     = 6;

  // Frame layout inside the 14-bit shift register; first bit shifted ends at the MSB.
  localparam int SEG_MSB = 13;
  localparam int SEG_LSB = 6;
  localparam int SEL_MSB = 5;
  localparam int SEL_LSB = 0;
  localparam int SEG_DP  = 7;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;

  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef struct packed {
    logic       hit;
    logic       minus;
    logic [3:0] nibble;
  } seg_dec_t;

  function automatic logic is_onehot6(input logic [5:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (v[i]) n++;
    end
    return (n == 1);
  endfunction

endpackage

// File: rtl/hc595_capture_seg7_decode.sv
// Combinational seven-segment pattern decoder; the dp bit is excluded so a lit
// decimal point never hides the digit value.
module seg7_decode
  import hc595_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       hit,
  output logic       minus,
  output logic [3:0] nibble
);

  always_comb begin
    hit    = 1'b1;
    minus  = 1'b0;
    nibble = 4'h0;
    case ({1'b1, pattern})
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_MINUS: begin
        hit   = 1'b0;
        minus = 1'b1;
      end
      default:   hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/hc595_capture.sv
// Oversampling receiver for a two-chip 74HC595 display chain: rebuilds the latched
// seg/sel word and decodes accepted frames into a six-digit buffer.
module hc595_capture
  import hc595_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        shcp,
  input  logic        stcp,
  input  logic        ds,
  input  logic        oe,
  output logic [7:0]  seg,
  output logic [5:0]  sel,
  output logic        frame_vld,
  output logic        frame_err,
  output logic [23:0] digits,
  output logic [5:0]  dig_ok,
  output logic [5:0]  dp,
  output logic [5:0]  minus
);

  // Pin vector order: {oe, ds, stcp, shcp}
  logic [3:0]            sync_q [SYNC_STAGES];
  logic [3:0]            hist_q;
  logic [3:0]            sync_out;
  logic                  shcp_rise;
  logic                  stcp_rise;
  logic                  ds_q;
  logic                  oe_q;

  logic [FRAME_BITS-1:0] sr;
  logic [3:0]            bit_cnt;
  logic [7:0]            seg_q;
  logic [5:0]            sel_q;

  logic                  dec_hit;
  logic                  dec_minus;
  logic [3:0]            dec_nibble;
  logic                  accept;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign ds_q     = hist_q[2];
  assign oe_q     = hist_q[3];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b0000;
      hist_q    <= 4'b0000;
      shcp_rise <= 1'b0;
      stcp_rise <= 1'b0;
    end else begin
      sync_q[0] <= {oe, ds, stcp, shcp};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q    <= sync_out;
      // Registered edge strobes stay aligned with ds_q/oe_q taken from hist_q.
      shcp_rise <= sync_out[0] & ~hist_q[0];
      stcp_rise <= sync_out[1] & ~hist_q[1];
    end
  end

  seg7_decode u_decode (
    .pattern (sr[SEG_MSB-1:SEG_LSB]),
    .hit     (dec_hit),
    .minus   (dec_minus),
    .nibble  (dec_nibble)
  );

  assign accept = (bit_cnt == 4'(FRAME_BITS)) && is_onehot6(sr[SEL_MSB:SEL_LSB]);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sr        <= '0;
      bit_cnt   <= 4'd0;
      seg_q     <= SEG_BLANK;
      sel_q     <= 6'h00;
      frame_vld <= 1'b0;
      frame_err <= 1'b0;
      digits    <= 24'h0;
      dig_ok    <= 6'h00;
      dp        <= 6'h00;
      minus     <= 6'h00;
    end else begin
      frame_vld <= 1'b0;
      frame_err <= 1'b0;

      if (shcp_rise) begin
        sr <= {sr[FRAME_BITS-2:0], ds_q};
        if (bit_cnt != 4'hF) bit_cnt <= bit_cnt + 4'd1;
      end

      if (stcp_rise) begin
        // Storage register reloads even for rejected frames, like the real part.
        seg_q   <= sr[SEG_MSB:SEG_LSB];
        sel_q   <= sr[SEL_MSB:SEL_LSB];
        bit_cnt <= shcp_rise ? 4'd1 : 4'd0;
        if (accept) begin
          frame_vld <= 1'b1;
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sr[SEL_LSB + i]) begin
              digits[4*i +: 4] <= dec_hit ? dec_nibble : 4'h0;
              dig_ok[i]        <= dec_hit;
              minus[i]         <= dec_minus;
              dp[i]            <= ~sr[SEG_MSB];
            end
          end
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

  assign seg = oe_q ? SEG_BLANK : seg_q;
  assign sel = oe_q ? 6'h00 : sel_q;

endmodule

// File: tb/tb_hc595_capture.sv
// Directed bench for hc595_capture: a pin-level 595 driver feeds the DUT while a
// reference model pushes expected frame results into a scoreboard queue.
module tb_hc595_capture;
  import hc595_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        shcp = 1'b0;
  logic        stcp = 1'b0;
  logic        ds = 1'b0;
  logic        oe = 1'b0;
  logic [7:0]  seg;
  logic [5:0]  sel;
  logic        frame_vld;
  logic        frame_err;
  logic [23:0] digits;
  logic [5:0]  dig_ok;
  logic [5:0]  dp;
  logic [5:0]  minus;

  hc595_capture dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .shcp      (shcp),
    .stcp      (stcp),
    .ds        (ds),
    .oe        (oe),
    .seg       (seg),
    .sel       (sel),
    .frame_vld (frame_vld),
    .frame_err (frame_err),
    .digits    (digits),
    .dig_ok    (dig_ok),
    .dp        (dp),
    .minus     (minus)
  );

  always #10 sys_clk = ~sys_clk;

  typedef struct packed {
    logic        vld;
    logic [7:0]  seg;
    logic [5:0]  sel;
    logic [23:0] digits;
    logic [5:0]  ok;
    logic [5:0]  dp;
    logic [5:0]  minus;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [13:0] m_sr;
  int          m_cnt;
  logic [23:0] m_digits;
  logic [5:0]  m_ok, m_dp, m_minus;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic ref_decode(input logic [7:0] p, output logic hit, output logic mn,
                            output logic [3:0] nib);
    logic [7:0] q;
    q = {1'b1, p[6:0]};
    hit = 1'b1;
    mn  = 1'b0;
    nib = 4'h0;
    case (q)
      8'hC0: nib = 4'h0;
      8'hF9: nib = 4'h1;
      8'hA4: nib = 4'h2;
      8'hB0: nib = 4'h3;
      8'h99: nib = 4'h4;
      8'h92: nib = 4'h5;
      8'h82: nib = 4'h6;
      8'hF8: nib = 4'h7;
      8'h80: nib = 4'h8;
      8'h90: nib = 4'h9;
      8'h88: nib = 4'hA;
      8'h83: nib = 4'hB;
      8'hC6: nib = 4'hC;
      8'hA1: nib = 4'hD;
      8'h86: nib = 4'hE;
      8'h8E: nib = 4'hF;
      8'hBF: begin hit = 1'b0; mn = 1'b1; end
      default: hit = 1'b0;
    endcase
  endtask

  task automatic model_reset();
    m_sr = '0; m_cnt = 0; m_digits = '0; m_ok = '0; m_dp = '0; m_minus = '0;
  endtask

  task automatic model_shift(input logic b);
    m_sr  = {m_sr[12:0], b};
    m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
  endtask

  task automatic model_latch();
    exp_t e;
    logic hit, mn;
    logic [3:0] nib;
    int nsel;
    nsel = 0;
    for (int i = 0; i < 6; i++) if (m_sr[i]) nsel++;
    e.vld = (m_cnt == 14) && (nsel == 1);
    if (e.vld) begin
      ref_decode(m_sr[13:6], hit, mn, nib);
      for (int i = 0; i < 6; i++) begin
        if (m_sr[i]) begin
          m_digits[4*i +: 4] = hit ? nib : 4'h0;
          m_ok[i]    = hit;
          m_minus[i] = mn;
          m_dp[i]    = ~m_sr[13];
        end
      end
    end
    e.seg    = oe ? 8'hFF : m_sr[13:6];
    e.sel    = oe ? 6'h00 : m_sr[5:0];
    e.digits = m_digits;
    e.ok     = m_ok;
    e.dp     = m_dp;
    e.minus  = m_minus;
    sb.push_back(e);
    m_cnt = 0;
  endtask

  task automatic send_bit(input logic b);
    ds   = b;
    shcp = 1'b0;
    cyc(2);
    shcp = 1'b1;
    model_shift(b);
    cyc(2);
  endtask

  task automatic send_word(input logic [13:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  // stcp has just been raised by the caller; wait for the DUT pulse and score it.
  task automatic finish_latch(input string tag, input bit chk_lat);
    exp_t e;
    int   lat;
    bit   seen;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      cyc(1);
      lat++;
      if (frame_vld || frame_err) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $error("FAIL %s timeout observed=no_pulse expected=pulse", tag);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk({tag, " vld"},    32'(frame_vld), 32'(e.vld));
      chk({tag, " err"},    32'(frame_err), 32'(!e.vld));
      chk({tag, " seg"},    32'(seg),       32'(e.seg));
      chk({tag, " sel"},    32'(sel),       32'(e.sel));
      chk({tag, " digits"}, 32'(digits),    32'(e.digits));
      chk({tag, " dig_ok"}, 32'(dig_ok),    32'(e.ok));
      chk({tag, " dp"},     32'(dp),        32'(e.dp));
      chk({tag, " minus"},  32'(minus),     32'(e.minus));
      if (chk_lat) chk({tag, " latency"}, 32'(lat), 32'd4);
      cyc(1);
      chk({tag, " pulse_width"}, 32'({frame_vld, frame_err}), 32'd0);
    end
  endtask

  task automatic frame(input string tag, input logic [13:0] w, input int n, input bit chk_lat);
    send_word(w, n);
    stcp = 1'b1;
    model_latch();
    finish_latch(tag, chk_lat);
    stcp = 1'b0;
    cyc(2);
  endtask

  initial begin
    int pulses;
    logic [13:0] wx, ww;
    model_reset();

    cyc(3);
    chk("rst seg",    32'(seg),    32'hFF);
    chk("rst sel",    32'(sel),    32'h00);
    chk("rst digits", 32'(digits), 32'h0);
    chk("rst dig_ok", 32'(dig_ok), 32'h0);
    chk("rst pulses", 32'({frame_vld, frame_err}), 32'd0);
    sys_rst_n = 1'b1;
    cyc(4);

    frame("single", 14'b1010_0100_000001, 14, 1'b1);
    chk("single digit0", 32'(digits[3:0]), 32'h2);

    // Reset in the middle of a frame discards it and clears the buffer.
    send_word(14'b1001_1001_000010, 5);
    shcp = 1'b0;
    ds   = 1'b0;
    sys_rst_n = 1'b0;
    cyc(2);
    chk("midrst seg",    32'(seg),    32'hFF);
    chk("midrst sel",    32'(sel),    32'h00);
    chk("midrst digits", 32'(digits), 32'h0);
    chk("midrst dig_ok", 32'(dig_ok), 32'h0);
    sys_rst_n = 1'b1;
    model_reset();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (frame_vld || frame_err) pulses++;
    end
    chk("idle pulses", 32'(pulses), 32'd0);

    frame("scan5", {8'hBF, 6'b100000}, 14, 1'b1);
    frame("scan4", {8'hF9, 6'b010000}, 14, 1'b0);
    frame("scan3", {8'hA4, 6'b001000}, 14, 1'b0);
    frame("scan2", {8'h30, 6'b000100}, 14, 1'b0);
    frame("scan1", {8'h99, 6'b000010}, 14, 1'b0);
    frame("scan0", {8'h92, 6'b000001}, 14, 1'b0);
    chk("scan digits", 32'(digits), 32'h012345);
    chk("scan minus",  32'(minus),  32'b100000);
    chk("scan dig_ok", 32'(dig_ok), 32'b011111);
    chk("scan dp",     32'(dp),     32'b000100);

    frame("short", 14'b0_1000_0000_00001, 13, 1'b0);
    frame("badsel", {8'h80, 6'b000011}, 14, 1'b0);
    chk("badsel digits", 32'(digits), 32'h012345);

    // shcp and stcp rise together: latch sees the pre-shift word, count restarts at 1.
    wx = {8'h99, 6'b000100};
    ww = {8'h80, 6'b000010};
    for (int i = 13; i >= 1; i--) send_bit(wx[i]);
    ds   = ww[13];
    shcp = 1'b0;
    cyc(2);
    shcp = 1'b1;
    stcp = 1'b1;
    model_latch();
    model_shift(ww[13]);
    finish_latch("simul", 1'b1);
    stcp = 1'b0;
    cyc(2);
    frame("after_simul", ww, 13, 1'b0);
    chk("after_simul digit1", 32'(digits[7:4]), 32'h8);

    oe = 1'b1;
    cyc(5);
    chk("oe idle seg", 32'(seg), 32'hFF);
    chk("oe idle sel", 32'(sel), 32'h00);
    frame("oe_frame", {8'hF8, 6'b010000}, 14, 1'b0);
    chk("oe digit4", 32'(digits[19:16]), 32'h7);
    oe = 1'b0;
    cyc(5);
    chk("oe off seg", 32'(seg), 32'hF8);
    chk("oe off sel", 32'(sel), 32'b010000);

    chk("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
